// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path.
//   rcu_state_t : receiver control unit states
//   SYNC_BYTE   : SYNC pattern as it arrives in the shift register
package usb_rx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    CHECK,
    RCV,
    STORE,
    EOP_WAIT,
    BAD_WAIT,
    ERR_EOP,
    ERR_IDLE
  } rcu_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

endpackage

// File: rtl/usb_rcu.sv
// Receiver control unit: validates SYNC, strobes one FIFO write per data byte,
// detects end-of-packet and keeps a sticky framing-error flag.
// Ports:
//   clk, n_rst     : clock, asynchronous active-low reset
//   d_edge         : pulse on any D+ transition
//   eop            : SE0 level from the decoder
//   shift_enable   : bit-sample strobe
//   byte_received  : shift register holds 8 new bits
//   rcv_data       : shift register contents
//   rcving         : packet in progress
//   wenable        : one-cycle FIFO write strobe
//   r_error        : sticky error for the last packet
module usb_rcu
  import usb_rx_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       wenable,
  output logic       r_error
);

  localparam int unsigned BW = $clog2(MAX_BYTES + 1);
  localparam logic [BW-1:0] MaxCnt = BW'(MAX_BYTES);

  rcu_state_t    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic          r_error_q, r_error_d;
  logic          eop_sample;
  logic          bit_tick;

  assign eop_sample = eop & shift_enable;
  assign bit_tick   = shift_enable & ~eop;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    r_error_d  = r_error_q;

    unique case (state_q)
      IDLE: if (d_edge) state_d = START;

      START: begin
        if (byte_received)   state_d = CHECK;
        else if (eop_sample) state_d = ERR_EOP;
      end

      CHECK: begin
        if (rcv_data == SYNC_BYTE) begin
          state_d    = RCV;
          byte_cnt_d = '0;
        end else begin
          state_d = BAD_WAIT;
        end
      end

      RCV: begin
        if (bit_tick) bit_cnt_d = bit_cnt_q + 3'd1;
        // byte_received wins over a coincident EOP sample
        if (byte_received) begin
          bit_cnt_d = 3'd0;
          state_d   = (byte_cnt_q == MaxCnt) ? BAD_WAIT : STORE;
        end else if (eop_sample) begin
          state_d = (bit_cnt_q == 3'd0) ? EOP_WAIT : ERR_EOP;
        end
      end

      // STORE is only reached with byte_cnt < MaxCnt, so the increment cannot wrap.
      // A bit sample landing here still belongs to the next byte.
      STORE: begin
        byte_cnt_d = byte_cnt_q + BW'(1);
        if (bit_tick) bit_cnt_d = bit_cnt_q + 3'd1;
        state_d = RCV;
      end

      EOP_WAIT: if (d_edge) state_d = IDLE;
      BAD_WAIT: if (eop_sample) state_d = ERR_EOP;
      ERR_EOP:  if (d_edge) state_d = ERR_IDLE;
      ERR_IDLE: if (d_edge) state_d = START;
      default:  state_d = IDLE;
    endcase

    // Entry actions
    if (state_d == START && state_q != START) begin
      bit_cnt_d = 3'd0;
      r_error_d = 1'b0;
    end
    if (state_d == BAD_WAIT || state_d == ERR_EOP) r_error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= '0;
      r_error_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      r_error_q  <= r_error_d;
    end
  end

  assign rcving  = (state_q != IDLE) && (state_q != ERR_IDLE);
  assign wenable = (state_q == STORE);
  assign r_error = r_error_q;

endmodule

// File: doc/usb_rcu.md
# usb_rcu

Receiver control unit for the USB full-speed receive path. It sequences the datapath behind the line synchronizers: the edge detector, NRZI decoder, 8-bit shift register and RX FIFO. It validates the SYNC byte, issues one FIFO write per received data byte, detects end-of-packet, and flags framing errors until the next packet starts.

## Interface
- MAX_BYTES, default 64: maximum number of data bytes per packet (SYNC excluded); must be ≥1.
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- d_edge  input  1  one-cycle pulse on any transition of the synchronized D+ line.
- eop  input  1  level; decoder sees SE0 on the line.
- shift_enable  input  1  one-cycle bit-sample strobe from the timer.
- byte_received  input  1  one-cycle pulse; shift register holds 8 new bits.
- rcv_data  input  8  shift register contents; valid in the cycle byte_received is high.
- rcving  output  1  high while a packet is in progress.
- wenable  output  1  one-cycle FIFO write strobe.
- r_error  output  1  sticky error flag for the last packet.

## Operation
- Outputs are Moore, decoded from registered state; r_error is a dedicated register.
- Reset: state IDLE, bit_cnt 0, byte_cnt 0, rcving 0, wenable 0, r_error 0.
- "EOP sample" means eop && shift_enable in the same cycle.
- IDLE: on d_edge, go to START.
- START: rcving=1. bit_cnt clears and r_error clears on entry.
  - byte_received: go to CHECK.
  - EOP sample: go to ERR_EOP.
- CHECK: one cycle.
  - rcv_data == SYNC_BYTE (8'h80): go to RCV and clear byte_cnt.
  - Otherwise: go to BAD_WAIT.
- RCV: bit_cnt (3-bit) increments on shift_enable && !eop and clears on byte_received.
  - byte_received with byte_cnt < MAX_BYTES: go to STORE.
  - byte_received with byte_cnt == MAX_BYTES: go to BAD_WAIT; no write.
  - EOP sample with bit_cnt == 0: go to EOP_WAIT (normal end).
  - EOP sample with bit_cnt != 0: go to ERR_EOP (partial byte).
- STORE: wenable=1 for exactly one cycle; byte_cnt+1; go to RCV.
- EOP_WAIT: rcving=1. On d_edge (line returns to idle), go to IDLE.
- BAD_WAIT: rcving=1, r_error set. On EOP sample, go to ERR_EOP.
- ERR_EOP: rcving=1, r_error=1. On d_edge, go to ERR_IDLE.
- ERR_IDLE: rcving=0, r_error held at 1. On d_edge, go to START, which clears r_error.
- Priority when inputs coincide:
  - byte_received beats an EOP sample in START and RCV; the EOP sample is dropped.
  - d_edge is ignored in every state except IDLE, EOP_WAIT, ERR_EOP and ERR_IDLE.
- byte_cnt width is $clog2(MAX_BYTES+1) and it never wraps: the overlong check fires before any increment past MAX_BYTES.
- Reset asserted mid-packet returns all state to reset values immediately (asynchronous). Any partial FIFO write is the FIFO's concern; wenable drops at once.

## Timing
- d_edge in IDLE at cycle N: rcving=1 from N+1.
- SYNC byte_received at N (START): CHECK at N+1, RCV or BAD_WAIT at N+2. r_error rises at N+2 on a bad SYNC.
- Data byte_received at N (RCV): wenable=1 at N+1 only, back in RCV at N+2. Back-to-back bytes need ≥2 cycles between pulses; the timer guarantees 8 bit-periods.
- Normal EOP sample at N: EOP_WAIT at N+1. The following d_edge at M sets rcving=0 at M+1.
- r_error is never asserted for a good packet and stays high through ERR_IDLE until the START entry of the next packet.

## Structure
- Package usb_rx_pkg holds:
  - rcu_state_t enum (IDLE, START, CHECK, RCV, STORE, EOP_WAIT, BAD_WAIT, ERR_EOP, ERR_IDLE).
  - SYNC_BYTE = 8'h80.
  - Shared with the rest of the receiver.
- Single module with separate next-state and state-register processes; bit_cnt and byte_cnt are inline counters.
- No sub-module is required. If the counters are split out, use one rcu_counter with clear and enable.

## Test plan
- Reset mid-RCV (after 2 bytes) → rcving=0, wenable=0, r_error=0 at once; the next d_edge starts a fresh packet from START.
- Good packet: SYNC 8'h80, data 8'hA5, 8'h3C, EOP at bit_cnt 0 → two wenable pulses, each one cycle after byte_received; r_error=0; rcving falls the cycle after the final d_edge.
- Bad SYNC 8'h81 → no wenable; r_error=1 two cycles after byte_received. Stays 1 through EOP and idle, then clears on the next d_edge.
- Partial byte: SYNC, 8'h11, then EOP after 5 shift_enables → one wenable; ERR_EOP; r_error=1 after the closing d_edge.
- Overlong: MAX_BYTES=2, SYNC + 3 data bytes → exactly 2 wenables; BAD_WAIT on the 3rd byte; r_error=1.
- Coincident byte_received and EOP sample in RCV → STORE taken (one wenable); the packet ends only on a later EOP sample.
